// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type and event-code width helper for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;
  function automatic int code_w(input int rows, input int cols);
    return rows + cols;
  endfunction
endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if: valid/ready key-event channel
interface keypad_matrix_scanner_if
  import keypad_pkg::*;
#(parameter int CW = code_w(4, 4)) ();
  logic evt_valid;
  logic evt_ready;
  logic evt_press;
  logic [CW-1:0] evt_code;
  modport master (output evt_valid, evt_code, evt_press, input evt_ready);
  modport slave (input evt_valid, evt_code, evt_press, output evt_ready);
endinterface

// File: rtl/key_debouncer.sv
// key_debouncer: press/release debounce FSM evaluated once per dwell sample point
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DEBOUNCE_CNT = 3,
  localparam int CW = code_w(ROWS, COLS),
  localparam int DW = $clog2(DEBOUNCE_CNT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sample,
  input  logic [COLS-1:0] col,
  input  logic [ROWS-1:0] row,
  output logic            held,
  output logic [CW-1:0]   candidate,
  output logic            accept_press,
  output logic            accept_release,
  output logic            ghost,
  output logic            rotate
);
  state_t state, state_nx;
  logic [DW-1:0] count, count_nx, inc;
  logic [CW-1:0] cand_q, cand_nx, code;
  logic zero, one, done;
  assign code = {col, row};
  assign zero = col == '0;
  assign one = $countones(col) == 1;
  assign inc = count + 1'b1;
  assign done = inc == DW'(DEBOUNCE_CNT);
  assign held = state == HELD || state == RELEASE_DB;
  // the combinational candidate lets a DEBOUNCE_CNT=1 press report the key on its first sample
  assign candidate = cand_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= SCAN;
      cand_q <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      cand_q <= cand_nx;
      count <= count_nx;
    end
  always_comb begin
    state_nx = state;
    cand_nx = cand_q;
    count_nx = count;
    accept_press = 1'b0;
    accept_release = 1'b0;
    ghost = 1'b0;
    rotate = 1'b0;
    if (sample)
      case (state)
        SCAN:
          if (one) begin
            cand_nx = code;
            accept_press = DEBOUNCE_CNT == 1;
            state_nx = accept_press ? HELD : PRESS_DB;
            count_nx = accept_press ? '0 : DW'(1);
          end else begin
            ghost = !zero;
            rotate = 1'b1;
          end
        PRESS_DB:
          if (code == cand_q) begin
            accept_press = done;
            state_nx = done ? HELD : PRESS_DB;
            count_nx = done ? '0 : inc;
          end else begin
            state_nx = SCAN;
            count_nx = '0;
            rotate = 1'b1;
          end
        default:
          if (zero) begin
            accept_release = done;
            rotate = done;
            state_nx = done ? SCAN : RELEASE_DB;
            count_nx = done ? '0 : inc;
          end else begin
            state_nx = HELD;
            count_nx = '0;
          end
      endcase
  end
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: row-scanning keypad reader with debounced press/release events
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COLS-1:0]          col,
  output logic [ROWS-1:0]          row,
  keypad_matrix_scanner_if.master  evt,
  output logic                     key_held,
  output logic                     ghost,
  output logic                     overflow
);
  localparam int CW = code_w(ROWS, COLS);
  localparam int VW = $clog2(SCAN_DIV);
  logic [VW-1:0] dwell;
  logic sample, accept_press, accept_release, ghost_c, rotate, emit, take;
  logic evt_valid_q, evt_press_q;
  logic [CW-1:0] candidate, evt_code_q;
  assign sample = dwell == VW'(SCAN_DIV - 1);
  assign emit = accept_press | accept_release;
  assign take = !evt_valid_q || evt.evt_ready;
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_code = evt_code_q;
  assign evt.evt_press = evt_press_q;
  key_debouncer #(.ROWS(ROWS), .COLS(COLS), .DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debouncer (
    .clk(clk),
    .reset(reset),
    .sample(sample),
    .col(col),
    .row(row),
    .held(key_held),
    .candidate(candidate),
    .accept_press(accept_press),
    .accept_release(accept_release),
    .ghost(ghost_c),
    .rotate(rotate)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dwell <= '0;
      row <= ROWS'(1) << (ROWS - 1);
      ghost <= 1'b0;
      overflow <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_code_q <= '0;
      evt_press_q <= 1'b0;
    end else begin
      dwell <= sample ? '0 : dwell + 1'b1;
      row <= rotate ? {row[0], row[ROWS-1:1]} : row;
      ghost <= ghost_c;
      overflow <= emit && !take;
      // an event arriving on the accepting edge replaces the old one with no idle gap
      if (emit && take) begin
        evt_valid_q <= 1'b1;
        evt_code_q <= candidate;
        evt_press_q <= accept_press;
      end else if (evt.evt_ready) evt_valid_q <= 1'b0;
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed and random checks against a physical-keypad reference model
module tb_keypad_matrix_scanner;
  import keypad_pkg::*;
  localparam int ROWS = 4, COLS = 4, DIV = 4, DB = 3;
  logic clk = 1'b0, reset = 1'b0, ready = 1'b1;
  logic [COLS-1:0] col;
  logic [ROWS-1:0] row;
  logic key_held, ghost, overflow;
  logic [COLS-1:0] keys [ROWS];
  int checks = 0, errors = 0;
  keypad_matrix_scanner_if #(.CW(8)) bus ();
  assign bus.evt_ready = ready;
  keypad_matrix_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(DIV), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .evt(bus),
    .key_held(key_held), .ghost(ghost), .overflow(overflow)
  );
  always #5 clk = ~clk;
  // a closed switch connects its row drive to its column sense line
  always_comb begin
    col = '0;
    for (int r = 0; r < ROWS; r++) if (row[r]) col = col | keys[r];
  end
  // reference model: predicts at each falling edge what the next rising edge produces
  int m_phase, m_idx, m_run, m_quiet, ones;
  bit m_holding, m_valid, m_press, m_ghost, m_ovf, emit, eprs, rot;
  logic [3:0] m_cand_col;
  logic [7:0] m_hcode, m_code;
  function automatic logic [3:0] rowvec(input int i);
    logic [3:0] v;
    v = 4'b1000;
    return v >> i;
  endfunction
  always @(negedge clk) begin
    if (!reset) begin
      m_phase = 0; m_idx = 0; m_run = 0; m_quiet = 0; m_holding = 0;
      m_valid = 0; m_press = 0; m_code = 0; m_ghost = 0; m_ovf = 0;
    end else begin
      emit = 0; eprs = 0; rot = 0; m_ghost = 0; m_ovf = 0;
      if (m_phase == DIV - 1) begin
        ones = $countones(col);
        if (!m_holding) begin
          if (ones == 1 && (m_run == 0 || col == m_cand_col)) begin
            m_cand_col = col;
            m_run++;
            if (m_run == DB) begin
              m_holding = 1; m_quiet = 0; m_run = 0; emit = 1; eprs = 1;
              m_hcode = {col, rowvec(m_idx)};
            end
          end else begin
            m_ghost = (m_run == 0 && ones > 1);
            m_run = 0;
            rot = 1;
          end
        end else if (col == 0) begin
          m_quiet++;
          if (m_quiet == DB) begin m_holding = 0; emit = 1; eprs = 0; rot = 1; end
        end else m_quiet = 0;
      end
      m_phase = (m_phase + 1) % DIV;
      if (emit) begin
        if (!m_valid || ready) begin m_valid = 1; m_code = m_hcode; m_press = eprs; end
        else m_ovf = 1;
      end else if (m_valid && ready) m_valid = 0;
      if (rot) m_idx = (m_idx + 1) % ROWS;
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic clear_keys();
    for (int r = 0; r < ROWS; r++) keys[r] = '0;
  endtask
  task automatic test_reset();
    clear_keys();
    reset = 0;
    cyc(3);
    checks++; if (row !== 4'b1000) begin errors++; $display("FAIL reset_row got %b exp 1000", row); end
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.evt_valid); end
    checks++; if (bus.evt_code !== 8'h00) begin errors++; $display("FAIL reset_code got %h exp 00", bus.evt_code); end
    checks++; if ({bus.evt_press, key_held, ghost, overflow} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {bus.evt_press, key_held, ghost, overflow}); end
    reset = 1;
  endtask
  task automatic test_scan();
    logic [3:0] exp;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      exp = 4'b1000 >> ((k / 4) % 4);
      checks++; if (row !== exp) begin errors++; $display("FAIL scan_row k=%0d got %b exp %b", k, row, exp); end
      checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL scan_valid k=%0d got %b exp 0", k, bus.evt_valid); end
    end
  endtask
  task automatic test_press_release();
    int t;
    ready = 1;
    keys[2] = 4'b0010;
    t = 0;
    while (!bus.evt_valid && t < 80) begin cyc(1); t++; end
    checks++; if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL press_timeout got %b exp 1", bus.evt_valid); end
    checks++; if (bus.evt_code !== 8'b0010_0100) begin errors++; $display("FAIL press_code got %b exp 00100100", bus.evt_code); end
    checks++; if (bus.evt_press !== 1'b1) begin errors++; $display("FAIL press_flag got %b exp 1", bus.evt_press); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held got %b exp 1", key_held); end
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      checks++; if (row !== 4'b0100) begin errors++; $display("FAIL held_row got %b exp 0100", row); end
      checks++; if (bus.evt_valid !== m_valid) begin errors++; $display("FAIL held_valid got %b exp %b", bus.evt_valid, m_valid); end
    end
    clear_keys();
    t = 0;
    while (!bus.evt_valid && t < 40) begin cyc(1); t++; end
    checks++; if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL release_timeout got %b exp 1", bus.evt_valid); end
    checks++; if (bus.evt_code !== 8'b0010_0100) begin errors++; $display("FAIL release_code got %b exp 00100100", bus.evt_code); end
    checks++; if (bus.evt_press !== 1'b0) begin errors++; $display("FAIL release_flag got %b exp 0", bus.evt_press); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held got %b exp 0", key_held); end
    checks++; if (row !== 4'b0010) begin errors++; $display("FAIL release_row got %b exp 0010", row); end
  endtask
  task automatic test_ghost();
    int seen;
    logic [3:0] prev;
    seen = 0;
    prev = row;
    keys[$urandom_range(0, ROWS - 1)] = 4'b0110;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      seen += int'(ghost);
      checks++; if (ghost !== m_ghost) begin errors++; $display("FAIL ghost_pulse k=%0d got %b exp %b", k, ghost, m_ghost); end
      checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL ghost_valid k=%0d got %b exp 0", k, bus.evt_valid); end
    end
    checks++; if (seen == 0) begin errors++; $display("FAIL ghost_seen got %0d exp >0", seen); end
    checks++; if (row === prev && m_idx != 0) begin errors++; $display("FAIL ghost_scan got %b exp %b", row, rowvec(m_idx)); end
    clear_keys();
    cyc(8);
  endtask
  task automatic test_overflow();
    int t;
    ready = 0;
    keys[1] = 4'b1000;
    t = 0;
    while (!bus.evt_valid && t < 80) begin cyc(1); t++; end
    checks++; if ({bus.evt_valid, bus.evt_press, bus.evt_code} !== {2'b11, 8'b1000_0010}) begin errors++; $display("FAIL ovf_press got %b %b %b exp 1 1 10000010", bus.evt_valid, bus.evt_press, bus.evt_code); end
    clear_keys();
    t = 0;
    while (!overflow && t < 40) begin cyc(1); t++; end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", overflow); end
    checks++; if ({bus.evt_valid, bus.evt_press, bus.evt_code} !== {2'b11, 8'b1000_0010}) begin errors++; $display("FAIL ovf_retain got %b %b %b exp 1 1 10000010", bus.evt_valid, bus.evt_press, bus.evt_code); end
    cyc(1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_single got %b exp 0", overflow); end
    ready = 1;
    cyc(1);
    checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_accept got %b exp 0", bus.evt_valid); end
  endtask
  task automatic test_bounce();
    int t;
    t = 0;
    while (row !== 4'b0100 && t < 40) begin cyc(1); t++; end
    keys[2] = 4'b0010;
    cyc(8);
    clear_keys();
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      checks++; if ({bus.evt_valid, key_held} !== 2'b00) begin errors++; $display("FAIL bounce k=%0d got %b exp 00", k, {bus.evt_valid, key_held}); end
    end
  endtask
  task automatic test_reset_mid(input bit in_held);
    int t;
    ready = !in_held;
    keys[3] = 4'b0001;
    t = 0;
    while (!(in_held ? key_held : (m_run > 0)) && t < 80) begin cyc(1); t++; end
    checks++; if (t >= 80) begin errors++; $display("FAIL rstmid_reach held=%0d got timeout exp state", in_held); end
    #1 reset = 0;
    #1;
    checks++; if ({row, bus.evt_valid, bus.evt_code, bus.evt_press, key_held, ghost, overflow} !== {4'b1000, 13'b0})
      begin errors++; $display("FAIL rstmid_async held=%0d got %b exp 1000%b", in_held, {row, bus.evt_valid, bus.evt_code, bus.evt_press, key_held, ghost, overflow}, 13'b0); end
    clear_keys();
    ready = 1;
    cyc(2);
    reset = 1;
    for (int k = 0; k < 30; k++) begin
      cyc(1);
      checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_noevt held=%0d k=%0d got %b exp 0", in_held, k, bus.evt_valid); end
    end
  endtask
  task automatic test_random();
    int hold, mode, r;
    hold = 0;
    for (int k = 0; k < 4000; k++) begin
      cyc(1);
      checks++; if (row !== rowvec(m_idx)) begin errors++; $display("FAIL rnd_row k=%0d got %b exp %b", k, row, rowvec(m_idx)); end
      checks++; if ({key_held, ghost, overflow} !== {m_holding, m_ghost, m_ovf}) begin errors++; $display("FAIL rnd_flags k=%0d got %b exp %b", k, {key_held, ghost, overflow}, {m_holding, m_ghost, m_ovf}); end
      checks++; if (bus.evt_valid !== m_valid) begin errors++; $display("FAIL rnd_valid k=%0d got %b exp %b", k, bus.evt_valid, m_valid); end
      if (m_valid) begin
        checks++; if ({bus.evt_press, bus.evt_code} !== {m_press, m_code}) begin errors++; $display("FAIL rnd_event k=%0d got %b %b exp %b %b", k, bus.evt_press, bus.evt_code, m_press, m_code); end
      end
      ready = $urandom_range(0, 3) != 0;
      if (hold == 0) begin
        clear_keys();
        mode = $urandom_range(0, 19);
        r = $urandom_range(0, ROWS - 1);
        if (mode >= 8) keys[r] = 4'b0001 << $urandom_range(0, COLS - 1);
        if (mode >= 17) keys[r] = keys[r] | (4'b0001 << $urandom_range(0, COLS - 1));
        if (mode == 19) keys[(r + 1) % ROWS] = 4'b0001 << $urandom_range(0, COLS - 1);
        hold = $urandom_range(1, 60);
      end else hold--;
    end
    clear_keys();
    ready = 1;
  endtask
  initial begin
    test_reset();
    test_scan();
    test_press_release();
    test_ghost();
    test_overflow();
    test_bounce();
    test_reset_mid(0);
    test_reset_mid(1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_matrix_scanner.md
KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of row drive lines (2..16).
REQ-002 SHALL have parameter COLS, default 4, number of column sense lines (2..16).
REQ-003 SHALL have parameter SCAN_DIV, default 4, clocks per row dwell (>=2).
REQ-004 SHALL have parameter DEBOUNCE_CNT, default 3, consecutive identical dwell samples needed to accept press or release (>=1).
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port col  input  COLS  column sense, high = key closed in driven row.
REQ-008 SHALL have port row  output  ROWS  one-hot row drive.
REQ-009 SHALL have port evt_valid  output  1  event pending.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts event when high with evt_valid.
REQ-011 SHALL have port evt_code  output  COLS+ROWS  {col pattern, row pattern} of event key.
REQ-012 SHALL have port evt_press  output  1  1 = press, 0 = release.
REQ-013 SHALL have port key_held  output  1  level, high while a debounced key is held.
REQ-014 SHALL have ports ghost and overflow  output  1 each  single-cycle flags.

Function
REQ-015 Dwell counter SHALL count 0..SCAN_DIV-1 repeatedly; col SHALL be sampled only at count SCAN_DIV-1 ("sample point").
REQ-016 FSM states SHALL be SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-017 In SCAN, at a sample point with col==0, row SHALL rotate right one position (row[0] wraps to row[ROWS-1]) on the same edge.
REQ-018 In SCAN, sample with >1 col bit set SHALL pulse ghost, keep scanning (rotate row), and not enter PRESS_DB.
REQ-019 In SCAN, sample with exactly one col bit set SHALL latch candidate {col,row}, set debounce count to 1, freeze row, go PRESS_DB.
REQ-020 In PRESS_DB, sample equal to candidate SHALL increment count; on reaching DEBOUNCE_CNT go HELD and emit press event; any other sample SHALL return to SCAN and rotate row.
REQ-021 With DEBOUNCE_CNT=1, SCAN SHALL go directly to HELD and emit press at the first qualifying sample.
REQ-022 In HELD, row SHALL stay frozen; col==0 samples SHALL count toward DEBOUNCE_CNT (RELEASE_DB), any nonzero sample SHALL reset count and stay/return HELD.
REQ-023 On DEBOUNCE_CNT consecutive zero samples SHALL emit release event (same evt_code as press), go SCAN, rotate row.
REQ-024 key_held SHALL be high in HELD and RELEASE_DB only.
REQ-025 Event output SHALL be a one-entry register: evt_valid rises the clock after emission, holds evt_code/evt_press stable until evt_valid&&evt_ready edge, then clears.
REQ-026 Emission while pending and not accepted that cycle SHALL drop the new event and pulse overflow; emission on the accepting cycle SHALL load the new event (no gap).
REQ-027 Scanning SHALL never stall on evt_ready.

Reset
REQ-028 Reset low SHALL immediately force row = MSB one-hot (1000 for ROWS=4), FSM SCAN, dwell and debounce counts 0, evt_valid 0, evt_code 0, evt_press 0, key_held 0, ghost 0, overflow 0.
REQ-029 Reset asserted mid-debounce or with event pending SHALL discard all state; no release event SHALL follow.

Structure
REQ-030 FSM state enum and event-code width function SHALL live in shared package keypad_pkg.
REQ-031 Debounce logic SHALL be one sub-module key_debouncer (sample, candidate, count, accept outputs); scan/rotate and event register stay in top level.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-032 Reset release, col=0 -> row 1000,0100,0010,0001,1000 each held 4 clocks; evt_valid stays 0.
REQ-033 col=0010 while row=0100 held stable -> row frozen, press evt_code=8'b0010_0100, evt_press=1 after 3rd sample; key_held=1.
REQ-034 Release col=0 for 3 samples -> release event evt_code=8'b0010_0100, evt_press=0; row resumes at 0010.
REQ-035 col=0110 in any row -> ghost pulse, no event, scan continues.
REQ-036 evt_ready=0 across press and release -> press retained, overflow pulse on release; bounce (col toggles within 2 samples) -> no event.
REQ-037 reset low during PRESS_DB and HELD -> outputs per REQ-028 asynchronously, no event afterwards.
